// File: rtl/fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit
//
// IF-stage owner of the fetch PC. The unit advances the PC sequentially and
// accepts a redirect resolved in execute (pcSrcE/pcTargetE). It also produces
// the decode/execute squash strobes. A redirect that arrives while fetch is
// stalled is captured and replayed when the stall releases.
//
// Optional feature macro: FETCH_REDIRECT_STATS_EN
//   When defined, the unit adds a saturating 32-bit redirect counter on the
//   output redirCount.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   stallF       in   hold fetch PC this cycle
//   pcSrcE       in   execute-stage redirect request
//   pcTargetE    in   execute-stage redirect target [ADDR_W]
//   pcF          out  current fetch PC (registered) [ADDR_W]
//   pcPlus4F     out  pcF + PC_INC (combinational) [ADDR_W]
//   flushD       out  squash IF/ID this cycle (combinational)
//   flushE       out  squash ID/EX this cycle (combinational)
//   redirPending out  captured redirect waiting for stall release (registered)
//   redirCount   out  redirect load counter [32] (FETCH_REDIRECT_STATS_EN only)
// -----------------------------------------------------------------------------
module fetch_redirect_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000),
    parameter int unsigned       PC_INC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              pcSrcE,
    input  logic [ADDR_W-1:0] pcTargetE,
    output logic [ADDR_W-1:0] pcF,
    output logic [ADDR_W-1:0] pcPlus4F,
    output logic              flushD,
    output logic              flushE,
    output logic              redirPending
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]       redirCount
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Targets are word addresses, so the two low bits are always cleared.
    function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] addr);
        return addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pend_target_r;
    logic [ADDR_W-1:0] pend_target_next_s;
    logic              redir_pending_r;
    logic              load_target_s;
    logic              flush_d_s;
    logic              flush_e_s;

    // Sequential increment wraps modulo 2^ADDR_W, with no carry out.
    assign pcPlus4F     = pc_r + ADDR_W'(PC_INC);
    assign pcF          = pc_r;
    assign redirPending = redir_pending_r;
    assign flushD       = flush_d_s;
    assign flushE       = flush_e_s;

    // State, PC and pending-target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_RUN;
            pc_r            <= RESET_PC;
            pend_target_r   <= {ADDR_W{1'b0}};
            redir_pending_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            pc_r            <= pc_next_s;
            pend_target_r   <= pend_target_next_s;
            redir_pending_r <= (state_next_s == ST_HOLD);
        end
    end

    // Next state, next PC and pending-target capture.
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        pend_target_next_s = pend_target_r;
        load_target_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (pcSrcE) begin
                    if (stallF) begin
                        // Fetch is frozen, so park the target until the stall releases.
                        pend_target_next_s = align_target(pcTargetE);
                        state_next_s       = ST_HOLD;
                    end else begin
                        pc_next_s     = align_target(pcTargetE);
                        load_target_s = 1'b1;
                    end
                end else if (!stallF) begin
                    pc_next_s = pcPlus4F;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            ST_HOLD: begin
                // A new pcSrcE here comes from a wrong-path instruction and is dropped.
                if (!stallF) begin
                    pc_next_s     = pend_target_r;
                    load_target_s = 1'b1;
                    state_next_s  = ST_RUN;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Flush strobes decoded from the current state and inputs, for one cycle per event.
    always_comb begin
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        if (rst) begin
            flush_d_s = 1'b0;
            flush_e_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // E squashes on every accepted redirect. D squashes only when the
                    // PC actually moves, because a stalled IF/ID is held, not refilled.
                    flush_e_s = pcSrcE;
                    flush_d_s = pcSrcE & ~stallF;
                end
                ST_HOLD: begin
                    // flushE was already issued at capture time.
                    flush_e_s = 1'b0;
                    flush_d_s = ~stallF;
                end
                default: begin
                    flush_d_s = 1'b0;
                    flush_e_s = 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redir_count_r;

    assign redirCount = redir_count_r;

    // Saturating count of cycles in which pcF is loaded from a redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_count_r <= 32'h0000_0000;
        end else if (load_target_s && (redir_count_r != 32'hFFFF_FFFF)) begin
            redir_count_r <= redir_count_r + 32'd1;
        end else begin
            redir_count_r <= redir_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        pcSrcE;
    logic [31:0] pcTargetE;
    logic [31:0] pcF;
    logic [31:0] pcPlus4F;
    logic        flushD;
    logic        flushE;
    logic        redirPending;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state. The model tracks the architectural PC, whether a
    // redirect is parked, the parked target and the redirect count.
    logic [31:0] m_pc;
    bit          m_hold;
    logic [31:0] m_tgt;
    longint      m_cnt;

    fetch_redirect_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RST_PC),
        .PC_INC  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallF      (stallF),
        .pcSrcE      (pcSrcE),
        .pcTargetE   (pcTargetE),
        .pcF         (pcF),
        .pcPlus4F    (pcPlus4F),
        .flushD      (flushD),
        .flushE      (flushE),
        .redirPending(redirPending)
`ifdef FETCH_REDIRECT_STATS_EN
        ,
        .redirCount  (redirCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_flush_d();
        if (rst) return 1'b0;
        if (m_hold) return !stallF;
        return pcSrcE && !stallF;
    endfunction

    function automatic bit exp_flush_e();
        if (rst) return 1'b0;
        return !m_hold && pcSrcE;
    endfunction

    // Drive the inputs for the coming cycle, then let the combinational logic settle.
    task automatic set_in(input bit r, input bit s, input bit p, input logic [31:0] t);
        rst = r; stallF = s; pcSrcE = p; pcTargetE = t;
        #1;
    endtask

    // Advance one clock and step the model with the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pc = RST_PC; m_hold = 0; m_tgt = 32'h0; m_cnt = 0;
        end else if (m_hold) begin
            if (!stallF) begin
                m_pc = m_tgt; m_hold = 0; m_cnt = m_cnt + 1;
            end
        end else if (pcSrcE) begin
            if (stallF) begin
                m_tgt = {pcTargetE[31:2], 2'b00}; m_hold = 1;
            end else begin
                m_pc = {pcTargetE[31:2], 2'b00}; m_cnt = m_cnt + 1;
            end
        end else if (!stallF) begin
            m_pc = m_pc + 32'd4;
        end
        if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 1, 32'h0000_0F00);
        n_checks++;
        if (flushD !== 1'b0 || flushE !== 1'b0) begin
            n_fail++; $display("FAIL reset_cycle_flush: got D=%b E=%b expected 0/0", flushD, flushE);
        end
        tick();
        set_in(0, 0, 0, 32'h0);
        n_checks++;
        if (pcF !== 32'h0000_0100) begin
            n_fail++; $display("FAIL reset_pc: got %h expected 00000100", pcF);
        end
        n_checks++;
        if (redirPending !== 1'b0 || flushD !== 1'b0 || flushE !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got P=%b D=%b E=%b expected 0/0/0", redirPending, flushD, flushE);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 32'h0);
            n_checks++;
            if (pcPlus4F !== exp_pc + 32'd4 || flushD !== 1'b0 || flushE !== 1'b0) begin
                n_fail++; $display("FAIL seq_comb[%0d]: got plus4=%h D=%b E=%b expected %h/0/0", i, pcPlus4F, flushD, flushE, exp_pc + 32'd4);
            end
            tick();
            exp_pc = exp_pc + 32'd4;
            n_checks++;
            if (pcF !== exp_pc) begin
                n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pcF, exp_pc);
            end
        end
    endtask

    task automatic test_redirect();
        set_in(0, 0, 1, 32'h0000_0200);
        n_checks++;
        if (flushD !== 1'b1 || flushE !== 1'b1) begin
            n_fail++; $display("FAIL redir_flush: got D=%b E=%b expected 1/1", flushD, flushE);
        end
        tick();
        set_in(0, 0, 0, 32'h0);
        n_checks++;
        if (pcF !== 32'h0000_0200 || flushD !== 1'b0 || flushE !== 1'b0) begin
            n_fail++; $display("FAIL redir_pc: got pc=%h D=%b E=%b expected 00000200/0/0", pcF, flushD, flushE);
        end
        tick();
        n_checks++;
        if (pcF !== 32'h0000_0204) begin
            n_fail++; $display("FAIL redir_next: got %h expected 00000204", pcF);
        end
    endtask

    task automatic test_stalled_redirect();
        logic [31:0] held_pc;
        held_pc = pcF;
        set_in(0, 1, 1, 32'h0000_0300);
        n_checks++;
        if (flushE !== 1'b1 || flushD !== 1'b0) begin
            n_fail++; $display("FAIL hold_capture_flush: got D=%b E=%b expected 0/1", flushD, flushE);
        end
        tick();
        // Wrong-path redirect inside HOLD_REDIR must be ignored.
        set_in(0, 1, 1, 32'h0000_0400);
        n_checks++;
        if (flushE !== 1'b0 || flushD !== 1'b0 || redirPending !== 1'b1 || pcF !== held_pc) begin
            n_fail++; $display("FAIL hold_c2: got D=%b E=%b P=%b pc=%h expected 0/0/1/%h", flushD, flushE, redirPending, pcF, held_pc);
        end
        tick();
        set_in(0, 1, 0, 32'h0);
        n_checks++;
        if (flushE !== 1'b0 || redirPending !== 1'b1 || pcF !== held_pc) begin
            n_fail++; $display("FAIL hold_c3: got E=%b P=%b pc=%h expected 0/1/%h", flushE, redirPending, pcF, held_pc);
        end
        tick();
        set_in(0, 0, 0, 32'h0);
        n_checks++;
        if (flushD !== 1'b1 || flushE !== 1'b0 || redirPending !== 1'b1) begin
            n_fail++; $display("FAIL hold_release_flush: got D=%b E=%b P=%b expected 1/0/1", flushD, flushE, redirPending);
        end
        tick();
        n_checks++;
        if (pcF !== 32'h0000_0300 || redirPending !== 1'b0) begin
            n_fail++; $display("FAIL hold_release_pc: got pc=%h P=%b expected 00000300/0", pcF, redirPending);
        end
    endtask

    task automatic test_align_wrap();
        set_in(0, 0, 1, 32'h0000_0207);
        tick();
        n_checks++;
        if (pcF !== 32'h0000_0204) begin
            n_fail++; $display("FAIL align: got %h expected 00000204", pcF);
        end
        set_in(0, 0, 1, 32'hFFFF_FFFE);
        tick();
        set_in(0, 0, 0, 32'h0);
        n_checks++;
        if (pcF !== 32'hFFFF_FFFC || pcPlus4F !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_plus4: got pc=%h plus4=%h expected fffffffc/00000000", pcF, pcPlus4F);
        end
        tick();
        n_checks++;
        if (pcF !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_pc: got %h expected 00000000", pcF);
        end
    endtask

    task automatic test_reset_in_hold();
        set_in(0, 1, 1, 32'h0000_0500);
        tick();
        set_in(1, 1, 0, 32'h0);
        n_checks++;
        if (redirPending !== 1'b1 || flushD !== 1'b0 || flushE !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold_pre: got P=%b D=%b E=%b expected 1/0/0", redirPending, flushD, flushE);
        end
        tick();
        set_in(0, 0, 0, 32'h0);
        n_checks++;
        if (pcF !== 32'h0000_0100 || redirPending !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold_pc: got pc=%h P=%b expected 00000100/0", pcF, redirPending);
        end
        tick();
        n_checks++;
        if (pcF !== 32'h0000_0104) begin
            n_fail++; $display("FAIL rst_hold_discard: got %h expected 00000104", pcF);
        end
    endtask

`ifdef FETCH_REDIRECT_STATS_EN
    task automatic test_stats();
        set_in(1, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 32'h0);
        n_checks++;
        if (redirCount !== 32'd0) begin
            n_fail++; $display("FAIL stats_reset: got %0d expected 0", redirCount);
        end
        set_in(0, 0, 1, 32'h0000_0800);
        tick();
        set_in(0, 1, 1, 32'h0000_0900);
        tick();
        set_in(0, 0, 0, 32'h0);
        tick();
        n_checks++;
        if (redirCount !== 32'd2) begin
            n_fail++; $display("FAIL stats_two: got %0d expected 2", redirCount);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 40),
                   ($urandom_range(0, 99) < 30), $urandom());
            n_checks++;
            if (pcF !== m_pc || pcPlus4F !== m_pc + 32'd4 || redirPending !== m_hold ||
                flushD !== exp_flush_d() || flushE !== exp_flush_e()) begin
                n_fail++;
                $display("FAIL random[%0d]: got pc=%h p4=%h P=%b D=%b E=%b expected pc=%h p4=%h P=%b D=%b E=%b",
                         i, pcF, pcPlus4F, redirPending, flushD, flushE,
                         m_pc, m_pc + 32'd4, m_hold, exp_flush_d(), exp_flush_e());
            end
`ifdef FETCH_REDIRECT_STATS_EN
            n_checks++;
            if (redirCount !== m_cnt[31:0]) begin
                n_fail++; $display("FAIL random_count[%0d]: got %0d expected %0d", i, redirCount, m_cnt);
            end
`endif
            tick();
        end
    endtask

    initial begin
        m_pc = RST_PC; m_hold = 0; m_tgt = 32'h0; m_cnt = 0;
        rst = 1'b1; stallF = 1'b0; pcSrcE = 1'b0; pcTargetE = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_redirect();
        test_stalled_redirect();
        test_align_wrap();
        test_reset_in_hold();
`ifdef FETCH_REDIRECT_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
